uart_tx_buffered: RTL and testbench
===================================

# uart_tx_buffered

Buffered 8N1 UART transmitter: the transmit-side counterpart to the design's UART receiver. Accepts bytes over a valid/ready handshake into a small FIFO and serializes them LSB-first on a single TX line at a fixed baud rate. It sits between on-chip byte producers (status/echo logic) and the `uo_out` TX pin, and runs on the same 20 MHz clock as the LED driver.

## Interface
- `CLOCK_RATE`, 20000000, input clock frequency in Hz
- `BAUD_RATE`, 9600, serial bit rate in bit/s
- `DEPTH`, 4, FIFO depth in bytes; must be a power of two and at least 2

- `clk`  in  1  single system clock; all logic on rising edge
- `rst_n`  in  1  reset; asynchronous, active-low
- `enable`  in  1  when low, no new frame starts
- `in_data`  in  8  byte to transmit
- `in_valid`  in  1  producer presents `in_data`
- `in_ready`  out  1  FIFO can accept a byte this cycle
- `tx`  out  1  serial line; idles high
- `busy`  out  1  frame in progress or FIFO non-empty

## Operation
- Bit period `DIV = CLOCK_RATE / BAUD_RATE`, using integer truncation. The default is 2083 cycles.
- Baud counter width is `$clog2(DIV)`. The counter runs only while a frame is in progress and reloads at the start of every bit.
- FIFO:
  - `in_ready = !full`, combinational from the occupancy count.
  - A push happens on an edge where `in_valid & in_ready`.
  - A pop happens when the serializer loads a byte.
  - Push and pop on the same edge leave the count unchanged and must not corrupt data.
  - When full, a push is refused even if a pop occurs that edge, because `in_ready` is already low.
  - Pointers are `$clog2(DEPTH)` bits and wrap modulo `DEPTH`. The count is `$clog2(DEPTH)+1` bits.
- Serializer states:
  - IDLE: `tx=1`. If FIFO is non-empty and `enable` is high, pop into the shift register, drive `tx=0`, and go to START.
  - START: hold 0 for `DIV` cycles, then go to DATA with bit index 0.
  - DATA: drive `shift[0]` for `DIV` cycles per bit, shifting right after each. After bit 7, go to STOP.
  - STOP: hold 1 for `DIV` cycles. On the last cycle, if FIFO is non-empty and `enable` is high, pop and go directly to START with `tx=0`. Otherwise go to IDLE.
- `enable` is sampled only at frame-start decisions. Deasserting it mid-frame lets the current frame finish normally.
- `busy` = (state != IDLE) | (count != 0).
- `tx` is driven directly from a flop (glitch-free).

## Timing
- Reset values, applied asynchronously while `rst_n` is low:
  - `tx=1`, `in_ready=1`, `busy=0`.
  - FIFO empty, state IDLE, counters 0.
  - A frame in flight is abandoned and `tx` goes high immediately. No partial-frame recovery.
- Latency, with FIFO empty, serializer IDLE and `enable` high:
  - Byte accepted at edge N.
  - `tx` falls after edge N+1.
  - `busy` rises after edge N.
- Frame length is exactly `10*DIV` cycles: start, 8 data bits, stop.
- Back-to-back frames have no idle gap: the next start bit begins on the cycle after the stop bit's `DIV`-th cycle.
- `in_ready` deasserts after the edge that makes the count equal `DEPTH`. It reasserts after the edge that pops.
- After the final stop bit with FIFO empty, `busy` falls on the same edge that enters IDLE.

## Test plan
Use `CLOCK_RATE=16`, `BAUD_RATE=1` (DIV=16), `DEPTH=4` unless noted.
- **Reset:** hold `rst_n`=0 with random inputs. Expect `tx=1`, `in_ready=1`, `busy=0`. Release; expect no activity without `in_valid`.
- **Single byte:** push 0x55 at edge N.
  - `tx` low from N+1 for 16 cycles.
  - Then 1,0,1,0,1,0,1,0, 16 cycles each.
  - Then stop high for 16 cycles.
  - `busy` falls at frame end, i.e. 160 cycles after `tx` fell.
- **Fill/backpressure:** hold `in_valid` high with 0xA1..0xA6.
  - Exactly 5 bytes are accepted before the first `in_ready` low: 1 popped immediately plus 4 buffered.
  - Frames are contiguous with no gaps, are decoded by the bench monitor in order, and there are no drops or duplicates.
- **Simultaneous push/pop:** with 3 bytes buffered, push on the edge where STOP pops.
  - Count stays at 3.
  - All bytes are transmitted in order.
- **Enable:** deassert `enable` mid-frame with 2 bytes queued.
  - The current frame completes intact.
  - `tx` stays high and `busy` stays 1.
  - Reasserting `enable` starts the next frame one cycle later.
- **Reset mid-frame:** assert `rst_n`=0 during data bit 3.
  - `tx`=1 immediately, without waiting for a clock.
  - FIFO is emptied.
  - After release, a new byte 0x3C is transmitted correctly.
  - A 115200-baud sanity run at `CLOCK_RATE=20000000` gives DIV=173.

Source files
------------

// File: rtl/uart_tx_buffered.sv
// Purpose : buffered 8N1 UART transmitter; bytes enter a DEPTH-entry FIFO and leave LSB-first on tx.
// Latency : a byte accepted at edge N on an idle, enabled, empty transmitter drives the start bit after edge N+1.
// Backpres: in_ready = !full; a full FIFO refuses a push even on an edge where the serializer pops.
//
// Ports:
//   clk      - single system clock, rising edge
//   rst_n    - asynchronous active-low reset; abandons any frame in flight, tx returns high at once
//   enable   - gates frame starts only; a frame already started always completes
//   in_data  - byte to transmit
//   in_valid - producer presents in_data
//   in_ready - FIFO has room this cycle
//   tx       - serial line, idles high, registered
//   busy     - frame in progress or FIFO non-empty
module uart_tx_buffered #(
    parameter int CLOCK_RATE = 20000000,
    parameter int BAUD_RATE  = 9600,
    parameter int DEPTH      = 4
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       enable,
    input  logic [7:0] in_data,
    input  logic       in_valid,
    output logic       in_ready,
    output logic       tx,
    output logic       busy
);

    // Bit period in clock cycles (truncating division).
    localparam int DIV = CLOCK_RATE / BAUD_RATE;
    // Guard keeps the counter at least one bit wide for degenerate DIV=1.
    localparam int CW  = (DIV > 1) ? $clog2(DIV) : 1;
    localparam int PW  = $clog2(DEPTH);

    localparam logic [CW-1:0] BAUD_LAST = CW'(DIV - 1);
    localparam logic [PW:0]   FULL_CNT  = (PW + 1)'(DEPTH);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        DATA  = 2'd2,
        STOP  = 2'd3
    } state_t;

    // ------------------------------------------------------------------
    // Byte FIFO
    // ------------------------------------------------------------------
    logic [7:0]    mem [DEPTH];
    logic [PW-1:0] wr_ptr;
    logic [PW-1:0] rd_ptr;
    logic [PW:0]   count;
    logic          push;
    logic          pop;
    logic          fifo_empty;
    logic [7:0]    head_dat;

    assign in_ready   = (count != FULL_CNT);
    assign fifo_empty = (count == '0);
    assign push       = in_valid & in_ready;
    assign head_dat   = mem[rd_ptr];

    // Pointers are exactly PW bits, so they wrap modulo DEPTH on their own.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            // Simultaneous push and pop leave the occupancy unchanged.
            if (push && !pop) begin
                count <= count + 1'b1;
            end else if (pop && !push) begin
                count <= count - 1'b1;
            end
        end
    end

    // Storage needs no reset: an entry is only read after being written.
    // A pop never targets the slot being written, because a pop requires
    // a non-empty FIFO and a push requires a non-full one.
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= in_data;
        end
    end

    // ------------------------------------------------------------------
    // Serializer
    // ------------------------------------------------------------------
    state_t        state;
    state_t        state_nxt;
    logic [CW-1:0] baud_cnt;
    logic [CW-1:0] baud_nxt;
    logic [2:0]    bit_idx;
    logic [2:0]    bit_nxt;
    logic [7:0]    shift;
    logic [7:0]    shift_nxt;
    logic          tx_nxt;
    logic          bit_done;
    logic          can_start;

    assign bit_done  = (baud_cnt == BAUD_LAST);
    // enable only matters where a new frame could begin.
    assign can_start = !fifo_empty && enable;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            baud_cnt <= '0;
            bit_idx  <= '0;
            shift    <= '0;
            tx       <= 1'b1;
        end else begin
            state    <= state_nxt;
            baud_cnt <= baud_nxt;
            bit_idx  <= bit_nxt;
            shift    <= shift_nxt;
            tx       <= tx_nxt;
        end
    end

    // tx_nxt always carries the level of the bit the next cycle belongs to,
    // so the line comes straight from a flop with no decode glitches.
    always_comb begin
        state_nxt = state;
        baud_nxt  = baud_cnt;
        bit_nxt   = bit_idx;
        shift_nxt = shift;
        tx_nxt    = tx;
        pop       = 1'b0;

        case (state)
            IDLE: begin
                baud_nxt = '0;
                bit_nxt  = '0;
                tx_nxt   = 1'b1;
                if (can_start) begin
                    pop       = 1'b1;
                    shift_nxt = head_dat;
                    tx_nxt    = 1'b0;
                    state_nxt = START;
                end
            end

            START: begin
                if (bit_done) begin
                    baud_nxt  = '0;
                    bit_nxt   = '0;
                    tx_nxt    = shift[0];
                    state_nxt = DATA;
                end else begin
                    baud_nxt = baud_cnt + 1'b1;
                end
            end

            DATA: begin
                if (bit_done) begin
                    baud_nxt = '0;
                    if (bit_idx == 3'd7) begin
                        tx_nxt    = 1'b1;
                        state_nxt = STOP;
                    end else begin
                        // Next bit is shift[1]; it becomes shift[0] after the shift.
                        shift_nxt = {1'b0, shift[7:1]};
                        tx_nxt    = shift[1];
                        bit_nxt   = bit_idx + 3'd1;
                    end
                end else begin
                    baud_nxt = baud_cnt + 1'b1;
                end
            end

            STOP: begin
                if (bit_done) begin
                    baud_nxt = '0;
                    if (can_start) begin
                        // Chain straight into the next start bit: no idle gap.
                        pop       = 1'b1;
                        shift_nxt = head_dat;
                        tx_nxt    = 1'b0;
                        state_nxt = START;
                    end else begin
                        tx_nxt    = 1'b1;
                        state_nxt = IDLE;
                    end
                end else begin
                    baud_nxt = baud_cnt + 1'b1;
                end
            end

            default: begin
                baud_nxt  = '0;
                bit_nxt   = '0;
                tx_nxt    = 1'b1;
                state_nxt = IDLE;
            end
        endcase
    end

    assign busy = (state != IDLE) || (count != '0);

endmodule

// File: tb/tb_uart_tx_buffered.sv
// Purpose : self-checking bench for uart_tx_buffered at DIV=16, DEPTH=4, plus a 115200-baud instance.
// Latency : a scoreboard queue is filled at each accepted handshake and drained by a tx frame monitor.
// Backpres: the bench holds in_valid and observes in_ready to exercise the full FIFO.
module tb_uart_tx_buffered;

    localparam int DIV   = 16;
    localparam int FRAME = 10 * DIV;

    logic       clk;
    logic       rst_n;
    logic       enable;
    logic [7:0] in_data;
    logic       in_valid;
    logic       in_ready;
    logic       tx;
    logic       busy;

    logic [7:0] f_data;
    logic       f_valid;
    logic       f_ready;
    logic       f_tx;
    logic       f_busy;

    int n_chk  = 0;
    int n_pass = 0;
    int n_fail = 0;
    int cyc    = 0;
    int frames = 0;

    logic [7:0] sb[$];
    int         starts[$];

    // Frame monitor state
    bit         mon_act = 1'b0;
    bit         mon_has;
    int         mon_cnt;
    int         mon_bad;
    int         mon_seg;
    logic       mon_expb;
    logic [7:0] mon_exp;
    logic [7:0] mon_got;
    logic [7:0] mon_ref;

    // Main sequence variables
    int         n;
    int         bad;
    int         idx;
    int         acc_before;
    int         base;
    int         f0;
    int         seg;
    int         lowc;
    int         busyc;
    bit         seen_low;
    logic       e;
    logic [7:0] b;

    uart_tx_buffered #(
        .CLOCK_RATE(16),
        .BAUD_RATE (1),
        .DEPTH     (4)
    ) u_dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .enable  (enable),
        .in_data (in_data),
        .in_valid(in_valid),
        .in_ready(in_ready),
        .tx      (tx),
        .busy    (busy)
    );

    uart_tx_buffered #(
        .CLOCK_RATE(20000000),
        .BAUD_RATE (115200),
        .DEPTH     (4)
    ) u_fast (
        .clk     (clk),
        .rst_n   (rst_n),
        .enable  (1'b1),
        .in_data (f_data),
        .in_valid(f_valid),
        .in_ready(f_ready),
        .tx      (f_tx),
        .busy    (f_busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic wait_idle(input string tag, input int budget);
        int k;
        k = 0;
        while ((busy !== 1'b0 || mon_act) && k < budget) begin
            @(negedge clk);
            k++;
        end
        check(tag, 32'(k < budget), 1);
    endtask

    // Decodes frames on tx at DIV=16, checking every cycle of every bit
    // against the head of the scoreboard, and pops it at the stop bit.
    always @(negedge clk) begin
        if (rst_n !== 1'b1) begin
            mon_act = 1'b0;
        end else begin
            if (!mon_act && tx === 1'b0) begin
                mon_act = 1'b1;
                mon_cnt = 0;
                mon_bad = 0;
                mon_got = '0;
                starts.push_back(cyc);
                mon_has = (sb.size() > 0);
                mon_exp = mon_has ? sb[0] : 8'h00;
            end
            if (mon_act) begin
                mon_seg  = mon_cnt / DIV;
                mon_expb = (mon_seg == 0) ? 1'b0 : (mon_seg == 9) ? 1'b1 : mon_exp[mon_seg-1];
                if (tx !== mon_expb) mon_bad++;
                if (mon_seg >= 1 && mon_seg <= 8 && (mon_cnt % DIV) == DIV / 2) mon_got[mon_seg-1] = tx;
                if (mon_cnt == FRAME - 1) begin
                    frames++;
                    mon_act = 1'b0;
                    check("frame_expected", 32'(mon_has), 1);
                    if (mon_has) begin
                        mon_ref = sb.pop_front();
                        check("frame_dat", mon_got, mon_ref);
                    end
                    check("frame_clean", mon_bad, 0);
                end else begin
                    mon_cnt++;
                end
            end
        end
    end

    initial begin
        rst_n    = 1'b0;
        enable   = 1'b1;
        in_valid = 1'b0;
        in_data  = 8'h00;
        f_valid  = 1'b0;
        f_data   = 8'hFF;

        // ---------------- reset with random inputs ----------------
        repeat (6) begin
            @(negedge clk);
            in_valid = 1'($urandom_range(0, 1));
            enable   = 1'($urandom_range(0, 1));
            in_data  = 8'($urandom);
        end
        check("rst_tx", tx, 1);
        check("rst_in_ready", in_ready, 1);
        check("rst_busy", busy, 0);
        @(negedge clk);
        in_valid = 1'b0;
        enable   = 1'b1;
        rst_n    = 1'b1;
        bad = 0;
        repeat (30) begin
            @(negedge clk);
            if (tx !== 1'b1 || busy !== 1'b0 || in_ready !== 1'b1) bad++;
        end
        check("idle_after_rst", bad, 0);

        // ---------------- single byte 0x55 ----------------
        b        = 8'h55;
        in_data  = b;
        in_valid = 1'b1;
        sb.push_back(b);
        @(negedge clk);
        in_valid = 1'b0;
        check("lat_busy_rise", busy, 1);
        check("lat_tx_high", tx, 1);
        @(negedge clk);
        check("lat_tx_fall", tx, 0);
        bad = 0;
        for (int k = 0; k < FRAME; k++) begin
            seg = k / DIV;
            e   = (seg == 0) ? 1'b0 : (seg == 9) ? 1'b1 : b[seg-1];
            if (tx !== e) bad++;
            if (k == FRAME - 1) check("busy_last_stop", busy, 1);
            @(negedge clk);
        end
        check("single_wave", bad, 0);
        check("busy_fall", busy, 0);
        check("single_frames", frames, 1);

        // ---------------- fill / backpressure ----------------
        f0         = frames;
        base       = starts.size();
        idx        = 0;
        seen_low   = 1'b0;
        acc_before = 0;
        n          = 0;
        in_valid   = 1'b1;
        while (idx < 6 && n < 1000) begin
            in_data = 8'hA1 + 8'(idx);
            if (!in_ready) begin
                seen_low = 1'b1;
            end else begin
                sb.push_back(in_data);
                idx++;
                if (!seen_low) acc_before++;
            end
            @(negedge clk);
            n++;
        end
        in_valid = 1'b0;
        check("fill_accepted", idx, 6);
        check("fill_before_full", acc_before, 5);
        wait_idle("fill_drain", 1500);
        check("fill_frames", frames - f0, 6);
        check("fill_sb_empty", sb.size(), 0);
        check("fill_nstarts", starts.size() - base, 6);
        if (starts.size() - base >= 6) begin
            for (int i = 0; i < 5; i++) check("fill_gap", starts[base+i+1] - starts[base+i], FRAME);
        end

        // ---------------- simultaneous push / pop ----------------
        f0 = frames;
        in_valid = 1'b1;
        for (int i = 0; i < 4; i++) begin
            in_data = 8'hB0 + 8'(i);
            sb.push_back(in_data);
            @(negedge clk);
        end
        in_valid = 1'b0;
        check("pp_ready_cnt3", in_ready, 1);
        repeat (157) @(negedge clk);
        check("pp_stop_bit", tx, 1);
        in_data  = 8'hB4;
        in_valid = 1'b1;
        sb.push_back(in_data);
        @(negedge clk);
        check("pp_next_start", tx, 0);
        check("pp_ready_after", in_ready, 1);
        in_data = 8'hB5;
        sb.push_back(in_data);
        @(negedge clk);
        in_valid = 1'b0;
        check("pp_count_kept", in_ready, 0);
        wait_idle("pp_drain", 1500);
        check("pp_frames", frames - f0, 6);
        check("pp_sb_empty", sb.size(), 0);

        // ---------------- enable gating ----------------
        f0 = frames;
        in_valid = 1'b1;
        for (int i = 0; i < 3; i++) begin
            in_data = 8'hC0 + 8'(i * 7);
            sb.push_back(in_data);
            @(negedge clk);
        end
        in_valid = 1'b0;
        repeat (50) @(negedge clk);
        enable = 1'b0;
        repeat (150) @(negedge clk);
        bad = 0;
        repeat (100) begin
            @(negedge clk);
            if (tx !== 1'b1 || busy !== 1'b1) bad++;
        end
        check("en_hold", bad, 0);
        check("en_one_frame", frames - f0, 1);
        enable = 1'b1;
        check("en_tx_before", tx, 1);
        @(negedge clk);
        check("en_restart", tx, 0);
        wait_idle("en_drain", 1000);
        check("en_frames", frames - f0, 3);
        check("en_sb_empty", sb.size(), 0);

        // ---------------- reset mid-frame ----------------
        f0 = frames;
        in_valid = 1'b1;
        for (int i = 0; i < 3; i++) begin
            in_data = (i == 0) ? 8'h96 : (i == 1) ? 8'h5A : 8'hC3;
            sb.push_back(in_data);
            @(negedge clk);
        end
        in_valid = 1'b0;
        repeat (70) @(negedge clk);
        check("mid_bit3_low", tx, 0);
        #2;
        rst_n = 1'b0;
        #1;
        check("mid_rst_tx", tx, 1);
        check("mid_rst_busy", busy, 0);
        check("mid_rst_ready", in_ready, 1);
        sb.delete();
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        bad = 0;
        repeat (40) begin
            @(negedge clk);
            if (tx !== 1'b1 || busy !== 1'b0) bad++;
        end
        check("mid_fifo_emptied", bad, 0);
        in_data  = 8'h3C;
        in_valid = 1'b1;
        sb.push_back(in_data);
        @(negedge clk);
        in_valid = 1'b0;
        wait_idle("mid_drain", 500);
        check("mid_frames", frames - f0, 1);
        check("mid_sb_empty", sb.size(), 0);

        // ---------------- 115200 baud at 20 MHz (DIV=173) ----------------
        check("fast_ready", f_ready, 1);
        f_data  = 8'hFF;
        f_valid = 1'b1;
        @(negedge clk);
        f_valid = 1'b0;
        lowc  = 0;
        busyc = 0;
        n     = 0;
        while (f_busy === 1'b1 && n < 3000) begin
            if (f_tx === 1'b0) lowc++;
            busyc++;
            @(negedge clk);
            n++;
        end
        check("fast_start_len", lowc, 173);
        check("fast_busy_len", busyc, 1731);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
